// File: rtl/probe_frame_sequencer.sv
// Tick-coherent probe capture: snapshots NCH channels on sim_tick and serialises them as
// 16-bit framed words into a FIFO drained by a pipe-out read port. Option: PROBE_TIMESTAMP_EN.
module probe_frame_sequencer #(
    parameter int NCH        = 4,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sim_tick,
    input  logic [NCH*32-1:0]     probe_in,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  busy,
    output logic [15:0]           drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef PROBE_TIMESTAMP_EN
    localparam int TSW = 2;
`else
    localparam int TSW = 0;
`endif
    localparam int FW = 1 + TSW + 2 * NCH;
    localparam int PW = (FW - 1) * 16;
    localparam int IW = $clog2(FW);
    localparam int CW = DEPTH_LOG2 + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            seq_q, seq_d;
    logic [7:0]            hdr_q, hdr_d;
    logic [PW-1:0]         shadow_q, shadow_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic [15:0]           drop_q, drop_d;
    logic [15:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  busy_q, busy_d;
`ifdef PROBE_TIMESTAMP_EN
    logic [31:0]           ts_q, ts_d;
`endif

    logic [15:0] mem [DEPTH];
    logic        tick_en, space_ok, push, pop, drop_evt;
    logic [15:0] push_word;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        hdr_d      = hdr_q;
        shadow_d   = shadow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        drop_d     = drop_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        push       = 1'b0;
        push_word  = 16'h0000;
        drop_evt   = 1'b0;
`ifdef PROBE_TIMESTAMP_EN
        ts_d       = ts_q;
`endif
        tick_en  = sim_tick && enable;
        // Free space is checked once per frame, so a frame never overflows once started.
        space_ok = (32'(fill_q) + 32'(FW)) <= 32'(DEPTH);
        pop      = rd_en && (fill_q != '0);

        if (tick_en) begin
            seq_d = seq_q + 8'd1;
`ifdef PROBE_TIMESTAMP_EN
            ts_d  = ts_q + 32'd1;
`endif
        end

        case (state_q)
            IDLE: begin
                if (tick_en) begin
                    if (space_ok) begin
                        state_d = EMIT;
                        idx_d   = '0;
                        hdr_d   = seq_q;
`ifdef PROBE_TIMESTAMP_EN
                        shadow_d = {probe_in, ts_q};
`else
                        shadow_d = probe_in;
`endif
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            EMIT: begin
                push = 1'b1;
                if (idx_q == '0) begin
                    push_word = {8'hA5, hdr_q};
                end
                // Payload words sit in the shadow in emission order, lowest half-word first.
                for (int w = 0; w < FW - 1; w++) begin
                    if (idx_q == IW'(w + 1)) begin
                        push_word = shadow_q[w*16 +: 16];
                    end
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(FW - 1)) begin
                    state_d = IDLE;
                end
                if (tick_en) begin
                    drop_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop_evt && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        if (pop) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + CW'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - CW'(1);
        end

        busy_d = (state_d == EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            seq_q      <= 8'h00;
            hdr_q      <= 8'h00;
            shadow_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            drop_q     <= 16'h0000;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PROBE_TIMESTAMP_EN
            ts_q       <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            hdr_q      <= hdr_d;
            shadow_q   <= shadow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            drop_q     <= drop_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
`ifdef PROBE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
            if (push) begin
                mem[wr_ptr_q] <= push_word;
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fill_count = fill_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_probe_frame_sequencer.sv
// Directed bench for probe_frame_sequencer (NCH=2, DEPTH_LOG2=6): a vector table for the basic
// frame, then hand sequences for drops, overlap with reads, reset mid-frame and enable gating.
module tb_probe_frame_sequencer;
    localparam int NCH = 2;
    localparam int DL2 = 6;
    localparam int DEPTH = 1 << DL2;
`ifdef PROBE_TIMESTAMP_EN
    localparam int FW = 3 + 2 * NCH;
`else
    localparam int FW = 1 + 2 * NCH;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              sim_tick = 1'b0;
    logic [NCH*32-1:0] probe_in = '0;
    logic              rd_en = 1'b0;
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic [DL2:0]      fill_count;
    logic              busy;
    logic [15:0]       drop_count;

    probe_frame_sequencer #(.NCH(NCH), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sim_tick(sim_tick),
        .probe_in(probe_in), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fill_count(fill_count), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        rd;
        logic        exp_busy;
        int          exp_fill;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        chk_data;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_seq = 8'h00;
    logic [31:0] m_ts = 32'h0;
    int          m_fill = 0;
    int          m_drop = 0;
    logic [15:0] last_data = 16'h0000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic t, input logic e, input logic r);
        sim_tick = t;
        enable   = e;
        rd_en    = r;
        @(posedge clk);
        #1;
        sim_tick = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Reference for one enabled tick: accept into the expected stream or count a drop.
    task automatic model_tick(input bit busy_now);
        if (busy_now || (m_fill + FW > DEPTH)) begin
            m_drop++;
        end else begin
            exp_q.push_back({8'hA5, m_seq});
`ifdef PROBE_TIMESTAMP_EN
            exp_q.push_back(m_ts[15:0]);
            exp_q.push_back(m_ts[31:16]);
`endif
            for (int k = 0; k < NCH; k++) begin
                exp_q.push_back(probe_in[k*32 +: 16]);
                exp_q.push_back(probe_in[k*32+16 +: 16]);
            end
            m_fill += FW;
        end
        m_seq = m_seq + 8'd1;
        m_ts  = m_ts + 32'd1;
    endtask

    task automatic pop_step(input string name);
        logic [15:0] e;
        step(1'b0, 1'b1, 1'b1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h expected no word (scoreboard empty)", name, rd_data);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_valid"}, 32'(rd_valid), 32'd1);
            chk({name, "_data"}, 32'(rd_data), 32'(e));
            last_data = e;
        end
        m_fill--;
    endtask

    task automatic drain(input string name);
        while (m_fill > 0) pop_step(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        m_seq  = 8'h00;
        m_ts   = 32'h0;
        m_fill = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    function automatic vec_t mk(logic t, logic r, logic b, int f, logic v, logic [15:0] d, logic c);
        vec_t x;
        x.tick = t; x.rd = r; x.exp_busy = b; x.exp_fill = f;
        x.exp_valid = v; x.exp_data = d; x.chk_data = c;
        return x;
    endfunction

    initial begin
        logic [15:0] frame[$];

        // Power-on reset state.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        do_reset();

        // Basic frame through the vector table.
        probe_in = {32'h9ABCDEF0, 32'h12345678};
        model_tick(1'b0);
        frame = exp_q;
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 0, 1'b0, 16'h0, 1'b0));
        for (int k = 1; k < FW; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, k, 1'b0, 16'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, FW, 1'b0, 16'h0, 1'b0));
        for (int k = 0; k < FW; k++) tbl.push_back(mk(1'b0, 1'b1, 1'b0, FW - 1 - k, 1'b1, frame[k], 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b0, frame[FW-1], 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].tick, 1'b1, tbl[i].rd);
            if (i == 0) probe_in = {32'hCAFEF00D, 32'h0BADBEEF};
            chk($sformatf("t1_v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("t1_v%0d_fill", i), 32'(fill_count), 32'(tbl[i].exp_fill));
            chk($sformatf("t1_v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].chk_data) chk($sformatf("t1_v%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
        end
        chk("t1_hdr_const", 32'(frame[0]), 32'h0000A500);
        exp_q.delete();
        m_fill = 0;

        // Reset on the third EMIT cycle, after a drop, with rd_data non-zero.
        probe_in = {32'h11112222, 32'h33334444};
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        model_tick(1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_drop_pre", 32'(drop_count), 32'(m_drop));
        do_reset();
        chk("t5_fill", 32'(fill_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_drop", 32'(drop_count), 32'd0);
        chk("t5_valid", 32'(rd_valid), 32'd0);
        chk("t5_data", 32'(rd_data), 32'd0);
        idle(FW + 2);
        chk("t5_no_partial", 32'(fill_count), 32'd0);

        // Enable falls mid-frame: frame completes; a disabled tick changes nothing.
        probe_in = {32'h55556666, 32'h77778888};
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FW; i++) step(1'b0, 1'b0, 1'b0);
        chk("en_fill", 32'(fill_count), 32'(FW));
        chk("en_drop", 32'(drop_count), 32'd0);
        chk("en_busy", 32'(busy), 32'd0);
        chk("en_hdr_const", 32'(exp_q[0]), 32'h0000A500);
        drain("en_rd");
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        chk("en_hdr2_const", 32'(exp_q[0]), 32'h0000A501);
        drain("en_rd2");

        // Tick two cycles after an accepted tick is dropped; next header carries seq 2.
        do_reset();
        probe_in = {32'hA1B2C3D4, 32'hE5F60718};
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        model_tick(1'b1);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        chk("t3_fill", 32'(fill_count), 32'(FW));
        chk("t3_drop", 32'(drop_count), 32'd1);
        drain("t3_rd");
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        chk("t3_hdr_const", 32'(exp_q[0]), 32'h0000A502);
        drain("t3_rd2");

        // Continuous reads across a frame emission with words already queued.
        do_reset();
        probe_in = {32'h0F0F1E1E, 32'h2D2D3C3C};
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        pop_step("t4_pre");
        pop_step("t4_pre");
        chk("t4_fill_pre", 32'(fill_count), 32'(FW - 2));
        probe_in = {32'h4B4B5A5A, 32'h69697878};
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < FW; i++) pop_step("t4_ovl");
        chk("t4_fill_post", 32'(fill_count), 32'(m_fill));
        chk("t4_busy", 32'(busy), 32'd0);
        drain("t4_rd");
        step(1'b0, 1'b1, 1'b1);
        chk("t4_empty_valid", 32'(rd_valid), 32'd0);
        chk("t4_empty_hold", 32'(rd_data), 32'(last_data));

        // Fill the FIFO until frames no longer fit.
        do_reset();
        for (int t = 0; t < 13; t++) begin
            probe_in = {32'(t) ^ 32'hFFFF0000, 32'(t) * 32'h00010001};
            model_tick(1'b0);
            step(1'b1, 1'b1, 1'b0);
            idle(9);
        end
        chk("t2_fill", 32'(fill_count), 32'(m_fill));
        chk("t2_drop", 32'(drop_count), 32'(m_drop));
`ifndef PROBE_TIMESTAMP_EN
        chk("t2_fill_60", 32'(fill_count), 32'd60);
        chk("t2_drop_1", 32'(drop_count), 32'd1);
`endif
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        chk("t2_drop14", 32'(drop_count), 32'(m_drop));
        pop_step("t2_rd1");
        model_tick(1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(FW);
        chk("t2_fill15", 32'(fill_count), 32'(m_fill));
        chk("t2_drop15", 32'(drop_count), 32'(m_drop));
`ifndef PROBE_TIMESTAMP_EN
        chk("t2_fill_64", 32'(fill_count), 32'd64);
        chk("t2_hdr_last", 32'(exp_q[exp_q.size() - FW]), 32'h0000A50E);
`endif
        drain("t2_rd");
        chk("t2_fill_end", 32'(fill_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
